// File: rtl/fft_mux_sequencer_if.sv
// -----------------------------------------------------------------------------
// fft_mux_sequencer_if
//   Bundles the control handshake and the registered mux-select bus that run
//   between the top-level FFT controller and fft_mux_sequencer.
//
//   Signals:
//     start      controller -> sequencer   one-cycle transform request
//     en         controller -> sequencer   advance enable (low = freeze)
//     ld_data    sequencer  -> datapath    high during the LOAD phase
//     busy       sequencer  -> controller  high during LOAD and RUN
//     done       sequencer  -> controller  one-cycle pulse after last stage
//     stage_num  sequencer  -> datapath    current stage, 0..NUMSTAGES-1
//     counter    sequencer  -> datapath    position within current phase
//     m0_s..m3_s sequencer  -> datapath    registered mux selects
//
//   Modports: master = controller side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface fft_mux_sequencer_if #(
  parameter int NUMSTAGES = 5,
  parameter int STG_W     = 3
);
  localparam int CNT_W = NUMSTAGES - 2;

  logic             start;
  logic             en;
  logic             ld_data;
  logic             busy;
  logic             done;
  logic [STG_W-1:0] stage_num;
  logic [CNT_W-1:0] counter;
  logic             m0_s;
  logic [1:0]       m1_s;
  logic             m2_s;
  logic             m3_s;

  modport master (
    output start, en,
    input  ld_data, busy, done, stage_num, counter, m0_s, m1_s, m2_s, m3_s
  );

  modport slave (
    input  start, en,
    output ld_data, busy, done, stage_num, counter, m0_s, m1_s, m2_s, m3_s
  );
endinterface

// File: rtl/fft_mux_sequencer.sv
// -----------------------------------------------------------------------------
// fft_mux_sequencer
//   Load/stage sequencer and mux-select decoder for a radix-2 pipelined FFT
//   of size 2^NUMSTAGES. A start pulse launches a LOAD phase of 2^CNT_W
//   cycles, followed by NUMSTAGES RUN stages of 2^CNT_W cycles each, then a
//   one-cycle DONE pulse. Everything freezes while en is low.
//
//   Ports:
//     clk  input   rising-edge clock
//     rst  input   asynchronous, active-high reset
//     bus  slave   fft_mux_sequencer_if (start/en in; status, counters and
//                  mux selects out, all registered)
// -----------------------------------------------------------------------------
module fft_mux_sequencer #(
  parameter int NUMSTAGES = 5,
  parameter int CNT_W     = NUMSTAGES - 2,
  parameter int STG_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_mux_sequencer_if.slave   bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUMSTAGES - 1);
  localparam logic [STG_W-1:0] M3_STG   = STG_W'(NUMSTAGES - 2);

  logic [1:0]       state, state_nx;
  logic [STG_W-1:0] stage_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] k;
  logic [1:0]       m1_nx;
  logic             m2_nx;
  logic             m3_nx;

  // Next-state: phase, stage and counter. With en low nothing changes, so the
  // registered outputs below recompute to their current values and hold.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_nx = state;
    stage_nx = bus.stage_num;
    cnt_nx   = bus.counter;
    if (bus.en) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_nx = LOAD;
            stage_nx = '0;
            cnt_nx   = '0;
          end
        end
        LOAD: begin
          cnt_nx = bus.counter + CNT_W'(1);
          if (bus.counter == CNT_MAX) begin
            state_nx = RUN;
            stage_nx = '0;
          end
        end
        RUN: begin
          cnt_nx = bus.counter + CNT_W'(1);
          if (bus.counter == CNT_MAX) begin
            if (bus.stage_num == LAST_STG) begin
              state_nx = DONE_ST;
              stage_nx = '0;
            end else begin
              stage_nx = bus.stage_num + STG_W'(1);
            end
          end
        end
        default: begin
          state_nx = IDLE;
          stage_nx = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Select decode from next-state, so the registered selects line up with the
  // stage_num/counter registered in the same edge. k is the top stage_num bits
  // of the counter: the butterfly group index within the current stage.
  always_comb begin
    k     = '0;
    m1_nx = 2'b00;
    m2_nx = 1'b0;
    m3_nx = 1'b0;
    if (state_nx == RUN) begin
      m3_nx = (stage_nx >= M3_STG);
      if (stage_nx == '0) begin
        m1_nx = 2'b10;
      end else if (stage_nx == LAST_STG) begin
        m2_nx = 1'b1;
      end else begin
        k = cnt_nx >> (CNT_W - int'(stage_nx));
        if (k == '0) begin
          m2_nx = 1'b1;
        end else if (k[0]) begin
          m1_nx = 2'b01;
        end else begin
          m1_nx = 2'b10;
          m2_nx = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.ld_data   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.stage_num <= '0;
      bus.counter   <= '0;
      bus.m0_s      <= 1'b1;
      bus.m1_s      <= 2'b00;
      bus.m2_s      <= 1'b0;
      bus.m3_s      <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.ld_data   <= (state_nx == LOAD);
      bus.busy      <= (state_nx == LOAD) || (state_nx == RUN);
      bus.done      <= (state_nx == DONE_ST);
      bus.stage_num <= stage_nx;
      bus.counter   <= cnt_nx;
      bus.m0_s      <= (state_nx != LOAD);
      bus.m1_s      <= m1_nx;
      bus.m2_s      <= m2_nx;
      bus.m3_s      <= m3_nx;
    end
  end

endmodule
